// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-bus responder with a synchronous RAM and a memory-mapped TX/RX FIFO window
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_addr,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  logic [7:0] ram [2**RAM_ADDR_WIDTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] dout_q, dout_d;
  logic ovf_q, ovf_d, full_q, full_d;
  logic is_io, is_data, is_stat, tx_pop, tx_push_req, tx_push, rx_push, rx_pop, ram_we;
  logic unused_addr;
  assign unused_addr = ^mem_addr[31:18];
  assign is_io = mem_addr[17];
  assign is_data = mem_addr[17:0] == 18'h30000;
  assign is_stat = mem_addr[17:0] == 18'h30004;
  assign tx_pop = tx_cnt_q != '0 && tx_ready;
  assign tx_push_req = rdy && mem_wr && is_data;
  assign tx_push = tx_push_req && (tx_cnt_q != DEPTH || tx_pop);
  assign rx_push = rx_valid && rx_cnt_q != DEPTH;
  assign rx_pop = rdy && !mem_wr && is_data && rx_cnt_q != '0;
  assign ram_we = rdy && mem_wr && !is_io;
  always_comb begin
    tx_wr_d = tx_wr_q + PW'(tx_push);
    tx_rd_d = tx_rd_q + PW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wr_d = rx_wr_q + PW'(rx_push);
    rx_rd_d = rx_rd_q + PW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    ovf_d = (rdy && mem_wr && is_stat) ? 1'b0 : ovf_q | (tx_push_req && !tx_push);
    full_d = tx_cnt_d >= CW'(FIFO_DEPTH - 2);
    dout_d = !rdy ? dout_q :
             mem_wr ? 8'h00 :
             !is_io ? ram[mem_addr[RAM_ADDR_WIDTH-1:0]] :
             is_data ? (rx_cnt_q != '0 ? rx_mem[rx_rd_q] : 8'h00) :
             is_stat ? {5'b0, ovf_q, rx_cnt_q != '0, tx_cnt_q == DEPTH} : 8'h00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      tx_cnt_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      rx_cnt_q <= '0;
      ovf_q <= 1'b0;
      full_q <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q <= ovf_d;
      full_q <= full_d;
      dout_q <= dout_d;
    end
  end
  // storage arrays carry no reset so they map onto plain memories
  always_ff @(posedge clk) begin
    if (ram_we) ram[mem_addr[RAM_ADDR_WIDTH-1:0]] <= mem_din;
    if (tx_push) tx_mem[tx_wr_q] <= mem_din;
    if (rx_push) rx_mem[rx_wr_q] <= rx_data;
  end
  assign mem_dout = dout_q;
  assign io_buffer_full = full_q;
  assign tx_data = tx_mem[tx_rd_q];
  assign tx_valid = tx_cnt_q != '0;
  assign rx_ready = rx_cnt_q != DEPTH;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed bench for ram_io_responder with immediate-assertion checks
module tb_ram_io_responder;
  logic clk = 1'b0;
  logic rst, rdy, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_addr;
  logic [7:0] mem_din, rx_data;
  logic [7:0] mem_dout, tx_data;
  logic io_buffer_full, tx_valid, rx_ready;
  int total = 0;
  int bad = 0;
  ram_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    mem_addr = a;
    mem_wr = w;
    mem_din = d;
    step();
    mem_addr = 32'h0;
    mem_wr = 1'b0;
    mem_din = 8'h00;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; rdy = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0; mem_din = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #3;
    check("rst_dout", mem_dout, 8'h00);
    check("rst_tx_valid", 8'(tx_valid), 8'h00);
    check("rst_rx_ready", 8'(rx_ready), 8'h01);
    check("rst_full", 8'(io_buffer_full), 8'h00);
    #9 rst = 1'b0;
    step();
    bus(32'h1000, 1'b1, 8'h11);
    check("wr_dout_zero", mem_dout, 8'h00);
    bus(32'h1001, 1'b1, 8'h22);
    bus(32'h1002, 1'b1, 8'h33);
    bus(32'h1003, 1'b1, 8'h44);
    for (int i = 0; i < 4; i++) begin
      mem_addr = 32'h1000 + 32'(i);
      step();
      check("ram_rd", mem_dout, 8'h11 * 8'(i + 1));
    end
    mem_addr = 32'h0;
    bus(32'h30000, 1'b1, 8'h41);
    check("tx1_valid", 8'(tx_valid), 8'h01);
    check("tx1_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("tx1_drained", 8'(tx_valid), 8'h00);
    for (int i = 1; i <= 10; i++) begin
      bus(32'h30000, 1'b1, 8'(i));
      check("almost_full", 8'(io_buffer_full), (i >= 6) ? 8'h01 : 8'h00);
    end
    check("tx_head", tx_data, 8'h01);
    bus(32'h30004, 1'b0, 8'h00);
    check("stat_ovf", mem_dout, 8'h05);
    bus(32'h30004, 1'b1, 8'hFF);
    bus(32'h30004, 1'b0, 8'h00);
    check("stat_clr", mem_dout, 8'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("tx_drain", tx_data, 8'(i));
      step();
    end
    tx_ready = 1'b0;
    check("tx_empty", 8'(tx_valid), 8'h00);
    check("full_clear", 8'(io_buffer_full), 8'h00);
    rx_valid = 1'b1; rx_data = 8'hA5;
    step();
    rx_data = 8'h5A;
    step();
    rx_valid = 1'b0;
    bus(32'h30004, 1'b0, 8'h00);
    check("stat_rx", mem_dout, 8'h02);
    bus(32'h30000, 1'b0, 8'h00);
    check("rx_a5", mem_dout, 8'hA5);
    bus(32'h30000, 1'b0, 8'h00);
    check("rx_5a", mem_dout, 8'h5A);
    bus(32'h30000, 1'b0, 8'h00);
    check("rx_empty", mem_dout, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i);
      step();
      check("rx_ready", 8'(rx_ready), (i == 7) ? 8'h00 : 8'h01);
    end
    rx_valid = 1'b0;
    bus(32'h20, 1'b1, 8'h99);
    bus(32'h30000, 1'b0, 8'h00);
    check("rx_first", mem_dout, 8'h10);
    rdy = 1'b0;
    bus(32'h20, 1'b1, 8'h77);
    check("hold_wr", mem_dout, 8'h10);
    bus(32'h30000, 1'b0, 8'h00);
    check("hold_rd", mem_dout, 8'h10);
    rdy = 1'b1;
    bus(32'h20, 1'b0, 8'h00);
    check("ram_kept", mem_dout, 8'h99);
    bus(32'h30000, 1'b0, 8'h00);
    check("no_pop", mem_dout, 8'h11);
    bus(32'h30000, 1'b1, 8'hC1);
    bus(32'h30000, 1'b1, 8'hC2);
    bus(32'h30000, 1'b1, 8'hC3);
    bus(32'h1001, 1'b0, 8'h00);
    check("pre_rst_dout", mem_dout, 8'h22);
    check("pre_rst_valid", 8'(tx_valid), 8'h01);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 8'(tx_valid), 8'h00);
    check("arst_full", 8'(io_buffer_full), 8'h00);
    check("arst_dout", mem_dout, 8'h00);
    check("arst_rx_ready", 8'(rx_ready), 8'h01);
    #2 rst = 1'b0;
    bus(32'h1002, 1'b0, 8'h00);
    check("ram_after_rst", mem_dout, 8'h33);
    bus(32'h1003, 1'b0, 8'h00);
    check("ram_after_rst2", mem_dout, 8'h44);
    bus(32'h30004, 1'b0, 8'h00);
    check("stat_after_rst", mem_dout, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
Memory-side responder for the CPU's byte-serial external bus. It answers byte reads and writes issued by the memory controller: a 1-cycle-latency synchronous RAM in the low region, and a memory-mapped IO window with TX/RX byte FIFOs toward a UART/host link. It drives io_buffer_full so the core can throttle IO stores.

Parameters:
RAM_ADDR_WIDTH, 17, byte-address bits of the RAM (128 KiB array).
FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; power of two, >= 4.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global enable; 0 freezes all bus-side state
mem_addr  input  32  byte address from the controller (out_addr)
mem_wr  input  1  1 = write byte, 0 = read byte (out_readwrite)
mem_din  input  8  write data from the controller (data_to_out)
mem_dout  output  8  read data to the controller (data_from_out), registered
io_buffer_full  output  1  TX FIFO almost full
tx_data  output  8  head byte of the TX FIFO
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  sink accepts tx_data this cycle
rx_data  input  8  incoming host byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  RX FIFO not full

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high. Reset values: mem_dout=0, tx_valid=0, rx_ready=1, io_buffer_full=0, all FIFO pointers/counts=0, overflow flag=0. RAM contents are not reset.
- Decode: mem_addr[17]=0 selects RAM and indexes it with mem_addr[RAM_ADDR_WIDTH-1:0]. mem_addr[17]=1 selects IO; only the offsets listed below are defined.
- RAM read: the address is sampled at edge N. mem_dout holds RAM[addr] after edge N+1. One access per cycle, with back-to-back incrementing addresses, so a 4-byte read completes in 4+1 cycles.
- RAM write: when mem_wr=1, RAM[addr] <= mem_din at the sampling edge. mem_dout after a write cycle = 0.
- IO 0x30000:
  - Write: push mem_din into the TX FIFO.
  - Read: pop the RX head into mem_dout (1-cycle latency); if RX is empty, mem_dout=0 and no pop.
  - Every read cycle at 0x30000 pops one byte.
- IO 0x30004:
  - Read: mem_dout = {5'b0, overflow, rx_nonempty, tx_full}.
  - Write: clears the overflow flag; the data is ignored.
- Other IO offsets: reads return 0; writes are ignored.
- rdy=0: no RAM write, no IO push/pop from the bus side, and mem_dout holds its value. TX drain and RX fill continue.
- TX FIFO:
  - tx_valid = count!=0 and tx_data = head, both driven from registers.
  - Pop on tx_valid && tx_ready.
  - A push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1 (sticky until cleared).
  - io_buffer_full = (count >= FIFO_DEPTH-2), registered from the post-update count.
- RX FIFO:
  - rx_ready = count!=FIFO_DEPTH.
  - Push on rx_valid && rx_ready.
  - A simultaneous bus pop and push is legal; count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits.
- rst asserted mid-transfer: everything returns to reset values immediately. Any in-flight byte is lost. The RAM retains its data.

Test Plan:
- RAM access: write bytes 0x11,0x22,0x33,0x44 to 0x1000..0x1003, then read 0x1000..0x1003 on consecutive cycles -> mem_dout = 0x11,0x22,0x33,0x44, each one cycle after its address.
- IO store with sink stalled: tx_ready=0, write 0x41 to 0x30000 -> tx_valid=1, tx_data=0x41. Then set tx_ready=1 for 1 cycle -> tx_valid=0.
- TX overflow and almost-full: tx_ready=0, write 10 bytes to 0x30000 (DEPTH=8).
  - io_buffer_full=1 after the 6th byte.
  - Bytes 9-10 are dropped.
  - Reading 0x30004 returns 0x05.
  - Writing 0x30004 clears overflow; a second read returns 0x01.
- RX path: drive rx_data 0xA5, 0x5A with rx_valid, then read 0x30000 three times -> mem_dout = 0xA5, 0x5A, 0x00.
  - Status before the reads = 0x02.
  - 8 pushes drive rx_ready=0.
- rdy hold: set rdy=0 during a write of 0x77 to RAM 0x20 and a read of 0x30000 -> RAM[0x20] is unchanged, no RX pop, and mem_dout holds its value.
- Asynchronous reset mid-burst: assert rst between clock edges while the TX FIFO holds 3 bytes -> tx_valid=0, io_buffer_full=0, mem_dout=0 immediately. Previously written RAM bytes still read back correctly.
